par3_out_serializer: RTL and testbench
======================================

Name: par3_out_serializer

Overview:
- Downstream stage of the 3-parallel FIR. Accepts one block per cycle: three 64-bit filter outputs (lane0 = dout1 = oldest, lane2 = dout3 = newest).
- Saturates each lane to a signed OUT_W sample and buffers blocks in a small block FIFO.
- Emits one sample per accepted handshake on a ready/valid stream, in lane order 0,1,2. Applies backpressure upstream when the FIFO is full.

Parameters:
- IN_W, 64, width of each input lane (signed, already scaled by the FIR).
- OUT_W, 16, width of the serial output sample (signed).
- DEPTH, 4, FIFO depth in 3-lane blocks; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  block present on in_lane0..2
- in_ready  output  1  block FIFO can accept a block
- in_lane0  input  IN_W  signed, oldest sample of the block
- in_lane1  input  IN_W  signed
- in_lane2  input  IN_W  signed, newest sample
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  OUT_W  signed saturated sample
- out_lane  output  2  lane index (0..2) of out_data
- level  output  $clog2(DEPTH)+1  number of blocks stored

Behaviour:
- Reset, asynchronous on rst high, applies immediately:
  - write pointer, read pointer, level and lane counter go to 0.
  - in_ready=1, out_valid=0, out_data=0, out_lane=0.
  - An in-flight block or partially drained block is discarded. No output until new data is written after rst falls.
- Saturation, applied per lane at write time; stored values are already OUT_W wide:
  - v > 2^(OUT_W-1)-1 gives 0x7FFF for OUT_W=16.
  - v < -2^(OUT_W-1) gives 0x8000.
  - Otherwise the low OUT_W bits of v.
- Push: occurs when in_valid && in_ready.
  - in_ready = (level != DEPTH), registered-state only.
  - No write-through when full, even if a pop happens in the same cycle.
  - When in_ready=0, input data is ignored, never overwritten.
- Output:
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr][lane]; out_lane = lane.
  - out_data is forced to 0 when out_valid=0.
- Pop/advance: on out_valid && out_ready:
  - If lane<2, lane increments.
  - If lane==2, lane goes to 0, rd_ptr increments modulo DEPTH, and the block is freed.
  - Without out_ready, out_data, out_lane and out_valid hold stable (AXI-style; valid is never withdrawn).
- Simultaneous push and final-lane pop in one cycle: level unchanged, both pointers advance.
- Push into an empty FIFO at cycle N gives out_valid=1 with lane0 at cycle N+1. Latency is 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Throughput:
  - Sustained 1 sample/cycle out.
  - Upstream accepts at most 1 block per 3 cycles in steady state.

Optional Feature:
- Macro PAR3_SAT_COUNT_EN.
- When defined:
  - Extra output port sat_cnt [15:0].
  - On each accepted push, sat_cnt increases by the number of lanes (0..3) that saturated. It sticks at 0xFFFF and does not wrap.
  - Reset value is 0.
- When undefined: no port, no counter logic. Datapath behaviour is identical.

Decomposition:
- Package par3_pkg:
  - localparam LANES=3.
  - typedef for the OUT_W sample (logic signed [15:0]).
  - typedef for a block (array of LANES samples).
  - Saturation min/max constants.
- Sub-module par3_sat: one-lane combinational saturator, IN_W to OUT_W, with a sat_flag output. Instantiated three times.
- Lane counter and FIFO control stay in the top module. No separate FSM module.

Test Plan:
- Reset then push (10, -20, 30) with out_ready=1 -> out_data 10/-20/30 on cycles N+1..N+3, out_lane 0/1/2; level returns to 0; out_valid=0 at N+4.
- Push (40000, -40000, 32767) -> outputs 32767, -32768, 32767. With PAR3_SAT_COUNT_EN, sat_cnt=2.
- out_ready=0, push 4 blocks back-to-back -> level=4, in_ready=0. A 5th block presented is ignored. Release out_ready -> 12 samples out in order, no loss or duplication.
- FIFO full, hold out_ready=1 -> in_ready rises the cycle after lane2 of the head block pops. Push plus pop in the same cycle keeps level constant.
- Toggle out_ready randomly mid-block -> out_data and out_lane stable while stalled, and the sequence matches a reference model.
- Assert rst while draining lane1 of block 2 -> out_valid=0 and level=0 immediately. The next push after rst falls emits lane0 of the new block.

Source files
------------

// File: rtl/par3_pkg.sv
// par3_pkg: shared lane count, sample/block types and saturation limits for the par3 serializer.
package par3_pkg;
  localparam int LANES = 3;
  localparam int SAMP_W = 16;
  typedef logic signed [SAMP_W-1:0] sample_t;
  typedef sample_t [LANES-1:0] block_t;
  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;
endpackage

// File: rtl/par3_sat.sv
// par3_sat: one-lane combinational saturator from a signed IN_W value to a signed OUT_W sample.
module par3_sat #(
  parameter int IN_W = 64,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_din,
  output logic [OUT_W-1:0] o_dout,
  output logic             o_sat
);
  logic [IN_W-OUT_W:0] w_top;
  assign w_top = i_din[IN_W-1:OUT_W-1];
  // the value fits only when every bit above the output sign matches it
  assign o_sat = !(&w_top || !(|w_top));
  assign o_dout = !o_sat ? i_din[OUT_W-1:0] :
                  i_din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
endmodule

// File: rtl/par3_out_serializer.sv
// par3_out_serializer: saturates 3-lane FIR blocks into a block FIFO and streams them out one sample per handshake.
// Optional PAR3_SAT_COUNT_EN adds a sticky 16-bit count of saturated lanes (sat_cnt).
module par3_out_serializer
  import par3_pkg::*;
#(
  parameter int IN_W = 64,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_lane0,
  input  logic [IN_W-1:0]          in_lane1,
  input  logic [IN_W-1:0]          in_lane2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [1:0]               out_lane,
  output logic [$clog2(DEPTH):0]   level
`ifdef PAR3_SAT_COUNT_EN
  , output logic [15:0]            sat_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [OUT_W-1:0] r_mem [DEPTH][LANES];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  logic [1:0] r_lane;
  logic [IN_W-1:0] w_in [LANES];
  logic [OUT_W-1:0] w_sat [LANES];
  logic [LANES-1:0] w_flag;
  logic w_push, w_pop, w_last;
  assign w_in[0] = in_lane0;
  assign w_in[1] = in_lane1;
  assign w_in[2] = in_lane2;
  for (genvar g = 0; g < LANES; g++) begin : g_sat
    par3_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat (
      .i_din(w_in[g]),
      .o_dout(w_sat[g]),
      .o_sat(w_flag[g])
    );
  end
  assign in_ready = r_level != (AW+1)'(DEPTH);
  assign out_valid = r_level != '0;
  assign out_data = out_valid ? r_mem[r_rd][r_lane] : '0;
  assign out_lane = r_lane;
  assign level = r_level;
  assign w_push = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  assign w_last = w_pop && r_lane == 2'd2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
      r_lane <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_last) r_rd <= r_rd + 1'b1;
      if (w_pop) r_lane <= w_last ? 2'd0 : r_lane + 2'd1;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_last};
    end
  end
  // storage carries no reset; validity is tracked by the level/pointers alone
  always_ff @(posedge clk) begin
    if (w_push) for (int i = 0; i < LANES; i++) r_mem[r_wr][i] <= w_sat[i];
  end
`ifdef PAR3_SAT_COUNT_EN
  logic [15:0] r_sat_cnt;
  logic [1:0] w_nsat;
  logic [16:0] w_sum;
  assign w_nsat = 2'(w_flag[0]) + 2'(w_flag[1]) + 2'(w_flag[2]);
  assign w_sum = {1'b0, r_sat_cnt} + 17'(w_nsat);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sat_cnt <= '0;
    else if (w_push) r_sat_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end
  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_flag;
  assign w_unused_flag = ^w_flag;
`endif
endmodule

// File: tb/tb_par3_out_serializer.sv
// tb_par3_out_serializer: table-driven vectors with a scoreboard queue checked on every output handshake.
module tb_par3_out_serializer;
  import par3_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] in_lane0 = 0, in_lane1 = 0, in_lane2 = 0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0] out_lane;
  logic [2:0] level;
`ifdef PAR3_SAT_COUNT_EN
  logic [15:0] sat_cnt;
`endif
  par3_out_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane0(in_lane0), .in_lane1(in_lane1), .in_lane2(in_lane2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .level(level)
`ifdef PAR3_SAT_COUNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic signed [63:0] a, b, c;
    sample_t ea, eb, ec;
    int ns;
  } vec_t;
  typedef struct {
    logic [15:0] d;
    logic [1:0] l;
  } exp_t;
  vec_t tv [8];
  exp_t sb [$];
  int n_chk = 0, n_fail = 0, exp_sat = 0;
  bit mon_en = 0, p_stall = 0;
  logic [15:0] p_data;
  logic [1:0] p_lane;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_in(input vec_t v);
    in_lane0 = v.a;
    in_lane1 = v.b;
    in_lane2 = v.c;
  endtask
  task automatic expect_blk(input vec_t v);
    sb.push_back('{v.ea, 2'd0});
    sb.push_back('{v.eb, 2'd1});
    sb.push_back('{v.ec, 2'd2});
    exp_sat += v.ns;
  endtask
  // call just after a rising edge; returns just after the edge that accepted the block
  task automatic push_blk(input vec_t v);
    int t = 0;
    in_valid = 1;
    set_in(v);
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_accept", in_ready, 1'b1);
    if (in_ready) expect_blk(v);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", {sb.size() == 0, out_valid}, 2'b10);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!mon_en) p_stall = 0;
    else begin
      if (p_stall) chk("stall_hold", {out_valid, out_lane, out_data}, {1'b1, p_lane, p_data});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", {out_lane, out_data}, 18'h3FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_lane", out_lane, e.l);
        end
      end
      p_stall = out_valid && !out_ready;
      p_data = out_data;
      p_lane = out_lane;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, lv;
    tv[0] = '{10, -20, 30, 16'h000A, 16'hFFEC, 16'h001E, 0};
    tv[1] = '{40000, -40000, 32767, 16'h7FFF, 16'h8000, 16'h7FFF, 2};
    tv[2] = '{32768, -32768, -32769, 16'h7FFF, 16'h8000, 16'h8000, 2};
    tv[3] = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh8000_0000_0000_0000, 0, 16'h7FFF, 16'h8000, 16'h0000, 2};
    tv[4] = '{-1, 1, 65535, 16'hFFFF, 16'h0001, 16'h7FFF, 1};
    tv[5] = '{64'sh1_0000_0005, -12345, 32766, 16'h7FFF, 16'hCFC7, 16'h7FFE, 1};
    tv[6] = '{-32767, 1234, -65536, 16'h8001, 16'h04D2, 16'h8000, 1};
    tv[7] = '{64'shFFFF_FFFF_FFFF_8000, 64'sh7FFF, 64'shFFFF_0000_0000_0000, 16'h8000, 16'h7FFF, 16'h8000, 1};
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_lane", out_lane, 2'd0);
    chk("rst_level", level, 3'd0);
`ifdef PAR3_SAT_COUNT_EN
    chk("rst_sat_cnt", sat_cnt, 16'h0);
`endif
    @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    out_ready = 1;
    push_blk(tv[0]);
    @(negedge clk);
    chk("lat1_valid_lane", {out_valid, out_lane, level}, {1'b1, 2'd0, 3'd1});
    repeat (3) @(negedge clk);
    chk("n4_empty", {out_valid, level}, {1'b0, 3'd0});
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_blk(tv[i]);
    wait_drain();
`ifdef PAR3_SAT_COUNT_EN
    chk("sat_cnt_table", sat_cnt, 16'(exp_sat));
`endif
    out_ready = 0;
    for (int i = 0; i < 4; i++) push_blk(tv[i]);
    @(negedge clk);
    chk("full_level", {level, in_ready}, {3'd4, 1'b0});
    in_valid = 1;
    set_in(tv[5]);
    repeat (3) begin
      @(negedge clk);
      chk("full_ignore", {level, in_ready}, {3'd4, 1'b0});
    end
    in_valid = 0;
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    chk("full_rdy_l0", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("full_rdy_l2", {in_ready, out_lane}, {1'b0, 2'd2});
    @(negedge clk);
    chk("rdy_after_free", {in_ready, level}, {1'b1, 3'd3});
    wait_drain();
    push_blk(tv[6]);
    t = 0;
    @(negedge clk);
    while (out_lane != 2'd2 && t < 10) begin
      @(negedge clk);
      t++;
    end
    lv = level;
    chk("pp_pre", {out_lane, in_ready}, {2'd2, 1'b1});
    in_valid = 1;
    set_in(tv[7]);
    expect_blk(tv[7]);
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("pp_level_const", {level, out_lane}, {3'(lv), 2'd0});
    wait_drain();
    fork
      for (int i = 0; i < 8; i++) push_blk(tv[$urandom_range(0, 7)]);
      repeat (120) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1;
    wait_drain();
    out_ready = 0;
    push_blk(tv[0]);
    push_blk(tv[1]);
    out_ready = 1;
    t = 0;
    @(negedge clk);
    while (!(level == 3'd1 && out_lane == 2'd1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("blk2_lane1", {level, out_lane}, {3'd1, 2'd1});
    #1 mon_en = 0;
    rst = 1;
    #1;
    chk("arst_immediate", {out_valid, level, in_ready, out_data, out_lane}, {1'b1 ^ 1'b1, 3'd0, 1'b1, 16'h0, 2'd0});
    sb.delete();
    exp_sat = 0;
    @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    @(negedge clk);
    chk("post_rst_idle", out_valid, 1'b0);
`ifdef PAR3_SAT_COUNT_EN
    chk("post_rst_sat", sat_cnt, 16'h0);
`endif
    @(posedge clk);
    #1;
    push_blk(tv[4]);
    @(negedge clk);
    chk("post_rst_lane0", {out_valid, out_lane, out_data}, {1'b1, 2'd0, 16'hFFFF});
    wait_drain();
`ifdef PAR3_SAT_COUNT_EN
    chk("post_rst_sat_cnt", sat_cnt, 16'(exp_sat));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
